// File: rtl/dlfloat_pkg.sv
// dlfloat_pkg: DLFloat16 operand type, format constants and loader FSM encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dlfloat_pkg;

  // DLFloat16: 1 sign bit, 6-bit exponent (bias 31), 9-bit mantissa.
  typedef struct packed {
    logic       sign;
    logic [5:0] exp;
    logic [8:0] mant;
  } dlfloat_t;

  localparam int       EXP_BIAS = 31;
  localparam dlfloat_t DLF_ZERO = 16'h0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LOAD,
    ST_DRAIN,
    ST_DONE
  } ld_state_e;

  // Exact match on the all-zero encoding; negative zero is issued like any other operand.
  function automatic logic dlf_is_zero(input dlfloat_t v);
    return v == DLF_ZERO;
  endfunction

endpackage

// File: rtl/dlfloat_pair_fifo.sv
// dlfloat_pair_fifo: synchronous FIFO of {a,b} operand pairs, power-of-two depth.
// Latency: a pushed entry is visible at the head one cycle after the push.
// Backpressure: push is dropped when full unless a pop frees the slot in the same cycle.
module dlfloat_pair_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         full,
  output logic         empty
);

  localparam int           AW       = $clog2(DEPTH);
  localparam logic [AW:0]  FULL_CNT = DEPTH[AW:0];

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  // Flags decode only the occupancy register, so they never depend on this cycle's pop.
  assign full     = (cnt_q == FULL_CNT);
  assign empty    = (cnt_q == '0);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign head_dat = mem_q[rd_q];

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_dat;
  end

endmodule

// File: rtl/dlfloat_vec_loader.sv
// dlfloat_vec_loader: assembles a byte stream into DLFloat16 (a,b) pairs and sequences one dot product on the MAC.
// Latency: a pair is offered to the MAC the cycle after its 4th byte; done fires MAC_LAT+1 cycles after the last issue.
// Backpressure: in_ready drops on the 4th byte while the pair FIFO is full; mac_* hold while mac_valid & !mac_ready.
// Optional: DLFLOAT_ZERO_SKIP_EN retires pairs with a zero operand without presenting them to the MAC.
module dlfloat_vec_loader
  import dlfloat_pkg::*;
#(
  parameter int LEN_W      = 8,
  parameter int FIFO_DEPTH = 2,
  parameter int MAC_LAT    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] vec_len,
  input  logic [7:0]       in_byte,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [15:0]      mac_a,
  output logic [15:0]      mac_b,
  output logic             mac_valid,
  input  logic             mac_ready,
  output logic             mac_clear,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] pair_cnt
);

  localparam logic [7:0] DRAIN_LAST = 8'(MAC_LAT - 1);

  ld_state_e        state_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] acc_q;     // pairs assembled and pushed
  logic [LEN_W-1:0] iss_q;     // pairs retired from the FIFO (issued or skipped)
  logic [LEN_W-1:0] iss_d;
  logic [1:0]       idx_q;     // byte position within the current pair
  logic [23:0]      buf_q;     // a[7:0], a[15:8], b[7:0] waiting for b[15:8]
  logic [7:0]       drain_q;
  logic             mac_clear_q;
  logic             busy_q;
  logic             done_q;

  logic             load_st;
  logic             byte_fire;
  logic             push;
  logic             pop;
  logic             skip;
  logic             fifo_full;
  logic             fifo_empty;
  logic [31:0]      push_dat;
  logic [31:0]      head_dat;
  dlfloat_t         head_a;
  dlfloat_t         head_b;

  assign load_st   = (state_q == ST_LOAD);
  // Uses the registered full flag so mac_ready never reaches in_ready combinationally.
  assign in_ready  = load_st & (acc_q < len_q) & ~((idx_q == 2'd3) & fifo_full);
  assign byte_fire = in_valid & in_ready;
  assign push      = byte_fire & (idx_q == 2'd3);
  assign push_dat  = {buf_q[15:0], in_byte, buf_q[23:16]};

  assign head_a = head_dat[31:16];
  assign head_b = head_dat[15:0];

`ifdef DLFLOAT_ZERO_SKIP_EN
  assign skip = dlf_is_zero(head_a) | dlf_is_zero(head_b);
`else
  assign skip = 1'b0;
`endif

  assign mac_valid = load_st & ~fifo_empty & ~skip;
  assign pop       = load_st & ~fifo_empty & (skip | mac_ready);
  assign iss_d     = (iss_q == len_q) ? iss_q : iss_q + LEN_W'(1);

  // Operands are zero whenever nothing is offered, so reset and idle both read as 0.
  assign mac_a     = mac_valid ? 16'(head_a) : 16'h0000;
  assign mac_b     = mac_valid ? 16'(head_b) : 16'h0000;
  assign mac_clear = mac_clear_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pair_cnt  = iss_q;

  dlfloat_pair_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (32)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .head_dat (head_dat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Sequencer: start capture, clear pulse, byte assembly, drain timer and done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      acc_q       <= '0;
      iss_q       <= '0;
      idx_q       <= '0;
      buf_q       <= '0;
      drain_q     <= '0;
      mac_clear_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      mac_clear_q <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            len_q       <= vec_len;
            acc_q       <= '0;
            iss_q       <= '0;
            idx_q       <= '0;
            drain_q     <= '0;
            mac_clear_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          state_q <= (len_q == '0) ? ST_DRAIN : ST_LOAD;
        end
        ST_LOAD: begin
          if (byte_fire) begin
            idx_q <= idx_q + 2'd1;
            case (idx_q)
              2'd0:    buf_q[7:0]   <= in_byte;
              2'd1:    buf_q[15:8]  <= in_byte;
              2'd2:    buf_q[23:16] <= in_byte;
              default: acc_q        <= acc_q + LEN_W'(1);
            endcase
          end
          if (pop) begin
            iss_q <= iss_d;
            if (iss_d == len_q) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (drain_q == DRAIN_LAST) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            drain_q <= drain_q + 8'd1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dlfloat_vec_loader.sv
// tb_dlfloat_vec_loader: directed bench for the DLFloat16 vector loader.
// Latency: drives on posedge+1, samples on negedge.
// Backpressure: exercises mac_ready stalls and in_ready throttling.
module tb_dlfloat_vec_loader;

  localparam int LEN_W   = 8;
  localparam int MAC_LAT = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] vec_len;
  logic [7:0]       in_byte;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      mac_a;
  logic [15:0]      mac_b;
  logic             mac_valid;
  logic             mac_ready;
  logic             mac_clear;
  logic             busy;
  logic             done;
  logic [LEN_W-1:0] pair_cnt;

  int          n_chk  = 0;
  int          n_pass = 0;
  int          cyc    = 0;
  int          iss_cyc = 0;
  int          start_cyc = 0;
  int          byte_cnt = 0;
  int          clr_cnt = 0;
  int          dc;
  logic [31:0] issued [$];

  dlfloat_vec_loader #(
    .LEN_W      (LEN_W),
    .FIFO_DEPTH (2),
    .MAC_LAT    (MAC_LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .vec_len   (vec_len),
    .in_byte   (in_byte),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mac_a     (mac_a),
    .mac_b     (mac_b),
    .mac_valid (mac_valid),
    .mac_ready (mac_ready),
    .mac_clear (mac_clear),
    .busy      (busy),
    .done      (done),
    .pair_cnt  (pair_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe transfers half a cycle after the driving edge.
  always @(negedge clk) begin
    if (mac_valid && mac_ready) begin
      issued.push_back({mac_a, mac_b});
      iss_cyc = cyc;
    end
    if (in_valid && in_ready) byte_cnt++;
    if (mac_clear) clr_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] qat(input int i);
    if (i < issued.size()) return issued[i];
    return 32'hDEADBEEF;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [LEN_W-1:0] len);
    start     = 1'b1;
    vec_len   = len;
    start_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n        = 0;
    in_byte  = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("byte_accept_timeout", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_pair(input logic [15:0] a, input logic [15:0] b);
    send_byte(a[7:0]);
    send_byte(a[15:8]);
    send_byte(b[7:0]);
    send_byte(b[15:8]);
  endtask

  task automatic wait_done(output int done_at);
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", {31'd0, done}, 32'd1);
    chk("busy_at_done", {31'd0, busy}, 32'd0);
    done_at = cyc;
    tick();
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    vec_len   = '0;
    in_byte   = 8'h00;
    in_valid  = 1'b0;
    mac_ready = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_flags", {27'd0, in_ready, mac_valid, mac_clear, busy, done}, 32'd0);
    chk("rst_pair_cnt", {24'd0, pair_cnt}, 32'd0);
    chk("rst_operands", {mac_a, mac_b}, 32'd0);
    rst = 1'b0;
    tick();

    // Basic vector: 1.0 x 2.0
    mac_ready = 1'b1;
    clr_cnt   = 0;
    issued.delete();
    do_start(8'd1);
    chk("t1_clear", {31'd0, mac_clear}, 32'd1);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    send_pair(16'h3E00, 16'h4000);
    wait_done(dc);
    chk("t1_n_issue", issued.size(), 32'd1);
    chk("t1_pair", qat(0), 32'h3E004000);
    chk("t1_done_lat", dc - iss_cyc, MAC_LAT + 1);
    chk("t1_clr_cnt", clr_cnt, 32'd1);
    chk("t1_busy_after", {31'd0, busy}, 32'd0);

    // Backpressure: MAC stalled while 4 pairs stream in
    mac_ready = 1'b0;
    issued.delete();
    byte_cnt = 0;
    do_start(8'd4);
    fork
      begin
        send_pair(16'h3E00, 16'h4000);
        send_pair(16'h4200, 16'h3C00);
        send_pair(16'hBE00, 16'h4100);
        send_pair(16'h3F00, 16'hC000);
      end
      begin
        repeat (16) @(posedge clk);
        @(negedge clk);
        chk("t2_bytes_stalled", byte_cnt, 32'd11);
        chk("t2_in_ready_low", {31'd0, in_ready}, 32'd0);
        chk("t2_valid_held", {31'd0, mac_valid}, 32'd1);
        chk("t2_head_a", {16'd0, mac_a}, 32'h3E00);
        chk("t2_head_b", {16'd0, mac_b}, 32'h4000);
        chk("t2_cnt_stalled", {24'd0, pair_cnt}, 32'd0);
        repeat (3) @(negedge clk);
        chk("t2_stable", {mac_a, mac_b}, 32'h3E004000);
        chk("t2_bytes_still", byte_cnt, 32'd11);
        tick();
        mac_ready = 1'b1;
      end
    join
    wait_done(dc);
    chk("t2_n_issue", issued.size(), 32'd4);
    chk("t2_pair0", qat(0), 32'h3E004000);
    chk("t2_pair1", qat(1), 32'h42003C00);
    chk("t2_pair2", qat(2), 32'hBE004100);
    chk("t2_pair3", qat(3), 32'h3F00C000);
    chk("t2_pair_cnt", {24'd0, pair_cnt}, 32'd4);

    // Zero length
    issued.delete();
    clr_cnt = 0;
    do_start(8'd0);
    wait_done(dc);
    chk("t3_done_lat", dc - start_cyc, MAC_LAT + 2);
    chk("t3_n_issue", issued.size(), 32'd0);
    chk("t3_clr_cnt", clr_cnt, 32'd1);

    // Reset mid-vector after 6 bytes
    mac_ready = 1'b0;
    do_start(8'd3);
    send_pair(16'h3E00, 16'h4000);
    send_byte(8'h00);
    send_byte(8'h42);
    chk("t4_valid_pre", {31'd0, mac_valid}, 32'd1);
    rst = 1'b1;
    #2;
    chk("t4_rst_flags", {27'd0, in_ready, mac_valid, mac_clear, busy, done}, 32'd0);
    chk("t4_rst_cnt", {24'd0, pair_cnt}, 32'd0);
    chk("t4_rst_operands", {mac_a, mac_b}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    mac_ready = 1'b1;
    issued.delete();
    do_start(8'd1);
    send_pair(16'h4100, 16'h3C00);
    wait_done(dc);
    chk("t4_n_issue", issued.size(), 32'd1);
    chk("t4_pair", qat(0), 32'h41003C00);

    // Ignored inputs: in_valid in IDLE, start during LOAD
    byte_cnt = 0;
    in_byte  = 8'hFF;
    in_valid = 1'b1;
    repeat (5) tick();
    in_valid = 1'b0;
    chk("t5_idle_bytes", byte_cnt, 32'd0);
    chk("t5_idle_busy", {31'd0, busy}, 32'd0);
    issued.delete();
    clr_cnt = 0;
    do_start(8'd2);
    send_pair(16'h4000, 16'h4000);
    start   = 1'b1;
    vec_len = 8'd5;
    tick();
    start = 1'b0;
    send_pair(16'h3E00, 16'hBE00);
    wait_done(dc);
    chk("t5_n_issue", issued.size(), 32'd2);
    chk("t5_pair1", qat(1), 32'h3E00BE00);
    chk("t5_pair_cnt", {24'd0, pair_cnt}, 32'd2);
    chk("t5_clr_cnt", clr_cnt, 32'd1);

    // Zero operand handling
    issued.delete();
    do_start(8'd3);
    send_pair(16'h3E00, 16'h4000);
    send_pair(16'h0000, 16'h4000);
    send_pair(16'h3E00, 16'h3E00);
    wait_done(dc);
    chk("t6_pair_cnt", {24'd0, pair_cnt}, 32'd3);
`ifdef DLFLOAT_ZERO_SKIP_EN
    chk("t6_n_issue", issued.size(), 32'd2);
    chk("t6_pair0", qat(0), 32'h3E004000);
    chk("t6_pair1", qat(1), 32'h3E003E00);
`else
    chk("t6_n_issue", issued.size(), 32'd3);
    chk("t6_pair1", qat(1), 32'h00004000);
    chk("t6_pair2", qat(2), 32'h3E003E00);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dlfloat_vec_loader.md
Name: dlfloat_vec_loader

Overview:
- Upstream sequencer for the DLFloat16 MAC (1 sign, 6 exponent with bias 31, 9 mantissa).
- Takes operands as a byte-wide stream on the 8-bit input pins and assembles them into 16-bit (a, b) pairs.
- Buffers pairs in a small FIFO and issues them to the MAC one per cycle under a ready handshake.
- Controls one dot product of programmable length: clears the accumulator at start, pulses done once the MAC pipeline has drained.

Parameters:
- LEN_W, 8, width of the vector-length and pair counters (max 255 pairs).
- FIFO_DEPTH, 2, pair FIFO entries; power of two, at least 2.
- MAC_LAT, 3, cycles from an issued pair to its result registered at the MAC output.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  begin a dot product; sampled only in IDLE
- vec_len  in  LEN_W  number of pairs; captured when start is accepted
- in_byte  in  8  operand byte stream
- in_valid  in  1  in_byte is valid
- in_ready  out  1  loader accepts in_byte this cycle
- mac_a  out  16  operand A to MAC
- mac_b  out  16  operand B to MAC
- mac_valid  out  1  mac_a/mac_b are valid
- mac_ready  in  1  MAC accepts the pair this cycle
- mac_clear  out  1  one-cycle accumulator clear
- busy  out  1  high from start acceptance to done
- done  out  1  one-cycle completion pulse
- pair_cnt  out  LEN_W  pairs issued, or counted, in the current vector

Behaviour:
- Reset (async, rst=1): state IDLE, FIFO empty, byte index 0, all counters 0. All outputs 0: in_ready, mac_valid, mac_a, mac_b, mac_clear, busy, done, pair_cnt. Reset mid-vector discards partial bytes and FIFO contents.
- Handshakes:
  - An input byte transfers on in_valid & in_ready.
  - A pair transfers to the MAC on mac_valid & mac_ready.
  - mac_a, mac_b and mac_valid stay stable while mac_valid & !mac_ready.
- FSM states: IDLE, CLEAR, LOAD, DRAIN, DONE.
  - IDLE: start=1 captures vec_len, zeroes the counters, moves to CLEAR.
  - CLEAR: mac_clear=1 for exactly one cycle; busy=1 from this cycle. Next state is LOAD, or DRAIN if vec_len=0.
  - LOAD: byte assembly, one byte per accepted transfer, order a[7:0], a[15:8], b[7:0], b[15:8].
    - The 4th byte pushes {a,b} into the FIFO on the same cycle it is accepted.
    - in_ready = (accepted pairs < vec_len) & !(byte index=3 & FIFO full).
    - The FIFO drives mac_* from its head.
    - Move to DRAIN when issued pairs = vec_len.
  - DRAIN: count MAC_LAT cycles after the last issue, then go to DONE.
  - DONE: done=1 for one cycle; busy drops the same cycle; next state IDLE.
- Simultaneous FIFO push and pop when full is legal: the pop frees the slot in the same cycle. in_ready still follows the registered full flag, so no combinational path runs from mac_ready to in_ready.
- start outside IDLE is ignored. in_valid outside LOAD is ignored; bytes are not consumed.
- pair_cnt increments on each issue and saturates at vec_len. Counters are LEN_W wide; no wrap inside one vector.
- Bubbles: mac_valid=0 cycles are allowed. The MAC must hold the accumulator when no valid pair is presented.

Optional Feature:
- Macro: DLFLOAT_ZERO_SKIP_EN.
- Defined: a pair with a==16'h0000 or b==16'h0000 is popped from the FIFO without asserting mac_valid. It still increments pair_cnt and counts toward vec_len.
- Undefined: every pair is issued.

Decomposition:
- Shared package dlfloat_pkg holds:
  - typedef dlfloat_t as 16-bit packed {sign, exp[5:0], mant[8:0]}.
  - EXP_BIAS=31 and DLF_ZERO=16'h0000.
  - The loader state enum.
- Sub-module dlfloat_pair_fifo: synchronous FIFO of 32-bit entries, depth FIFO_DEPTH, with full/empty flags and async active-high reset.

Test Plan:
- Basic vector:
  - Stimulus: vec_len=1; bytes 00,3E,00,40 (a=1.0=16'h3E00, b=2.0=16'h4000), mac_ready=1.
  - Required: mac_clear 1 cycle after start; one mac_valid with a=3E00, b=4000; done exactly MAC_LAT+1 cycles after the issue; busy low after done.
- Backpressure:
  - Stimulus: vec_len=4, mac_ready=0 for 20 cycles.
  - Required: FIFO fills with 2 pairs; in_ready low with byte index 3; mac_a/mac_b held stable; all 4 pairs issued in order after release; pair_cnt=4.
- Zero length:
  - Stimulus: vec_len=0.
  - Required: mac_clear pulse, no mac_valid, done MAC_LAT+2 cycles after start.
- Reset mid-vector:
  - Stimulus: rst asserted after 6 bytes of vec_len=3.
  - Required: all outputs 0 immediately; after release the next start loads cleanly from byte a[7:0].
- Ignored inputs:
  - Stimulus: start pulsed during LOAD, in_valid during IDLE.
  - Required: no effect; vec_len is unchanged and no bytes are consumed.
- Zero skip (DLFLOAT_ZERO_SKIP_EN defined):
  - Stimulus: vec_len=3, pairs (3E00,4000), (0000,4000), (3E00,3E00).
  - Required: exactly 2 mac_valid pulses, pair_cnt=3, done asserted.
